bounded_coeff_sampler: RTL and testbench
========================================

Name: bounded_coeff_sampler

Overview:
- Sequential rejection sampler for the ExpandS path of ML-DSA.
- Consumes a SHAKE256 byte stream and splits each byte into two nibbles, low nibble first.
- Applies CoeffFromHalfByte for the compile-time ETA, rejects out-of-range nibbles, and emits exactly N_COEFF signed coefficients over a valid/ready interface.
- Generalises the fixed eta=2 nibble LUT: selectable ETA, multi-byte input beats, rejection, backpressure and polynomial framing.

Parameters:
- ETA, 2, bound on coefficients. Only 2 or 4 are legal; any other value is an elaboration error.
- IN_BYTES, 1, bytes per input beat (1..8). Nibble order is byte 0 low, byte 0 high, byte 1 low, and so on.
- N_COEFF, 256, accepted coefficients per polynomial.
- COEFF_W, 4, signed output width. Must be at least 4 when ETA=4 and at least 3 when ETA=2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins one polynomial.
- in_valid  in  1  input beat valid.
- in_ready  out  1  sampler can accept a beat.
- in_data  in  8*IN_BYTES  byte stream, byte 0 in bits [7:0].
- out_valid  out  1  coefficient valid.
- out_ready  in  1  downstream accepts coefficient.
- out_coeff  out  COEFF_W  signed coefficient in [-ETA, ETA], two's complement.
- out_idx  out  $clog2(N_COEFF)  index of the current coefficient.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the last coefficient handshake.
- rej_cnt  out  16  rejected nibbles this polynomial, saturating at 16'hFFFF.

Behaviour:
- Reset (asynchronous, rst_n=0) values: state=IDLE, in_ready=0, out_valid=0, out_coeff=0, out_idx=0, busy=0, done=0, rej_cnt=0, nibble buffer empty.
- States: IDLE, RUN, DONE.
  - IDLE: start moves to RUN and clears out_idx and rej_cnt.
  - RUN: ends after the accepted coefficient with out_idx=N_COEFF-1 handshakes, then DONE.
  - DONE: lasts one cycle with done=1, then IDLE.
- Buffer: holds 2*IN_BYTES nibbles plus a nibble pointer.
- in_ready = (state==RUN) && buffer empty, driven from registers. A beat handshake (in_valid&&in_ready) loads the buffer and sets pointer=0. This costs one bubble cycle per beat.
- Evaluation is one nibble per cycle, combinational from the buffer registers, on nibble z:
  - ETA=2: accept if z<15; coeff = 2 - (z mod 5).
  - ETA=4: accept if z<9; coeff = 4 - z.
- Rejected nibble: out_valid=0; pointer advances next cycle; rej_cnt increments with saturation.
- Accepted nibble: out_valid=1 with out_coeff and out_idx stable until out_ready. On handshake, pointer and out_idx advance together.
- Latency: the first nibble of a beat is presented the cycle after the beat handshake.
- Buffer becomes empty when the last nibble is consumed. in_ready rises in the following cycle.
- Polynomial complete: unconsumed nibbles in the buffer are discarded and the buffer is emptied. in_ready stays 0 until the next start.
- start while busy or in DONE is ignored.
- in_valid outside RUN is ignored; in_ready is 0 there.
- Reset mid-polynomial aborts it. Nothing is resumed; a fresh start is required.
- out_valid never asserts outside RUN.
- The final handshake and the done pulse never coincide: done asserts in the cycle after the final handshake.

Optional Feature:
- Macro: COEFF_MODQ_OUT_EN.
- When defined, add output out_coeff_q (23 bits, unsigned). It carries the coefficient reduced mod q=8380417: non-negative values pass through, a negative c maps to q+c. It is valid under the same out_valid and is 0 at reset.
- When undefined, the port and its logic are absent. Signed behaviour is unchanged.

Test Plan:
- ETA=2, IN_BYTES=1, in_data=8'h3F, out_ready=1 -> nibble 15 rejected (rej_cnt=1); next output -1 (4'b1111), out_idx=0.
- ETA=2, in_data=8'h40 -> outputs 2 then -2, out_idx 0 then 1, rej_cnt=0.
- ETA=4, in_data=8'h98 -> output -4; nibble 9 rejected; rej_cnt=1.
- ETA=2, 128 beats of 8'h00, out_ready=1 -> 256 coefficients all equal to 2, last has out_idx=255, done pulses once on the next cycle, in_ready=0 afterwards; a 129th beat is not accepted.
- Backpressure: out_ready=0 for 5 cycles on an accepted coefficient -> out_valid, out_coeff and out_idx held, in_ready stays 0. The stream continues without loss on release.
- rst_n low mid-polynomial (out_idx=100) -> all outputs return to reset values immediately. A new start restarts at out_idx=0. With COEFF_MODQ_OUT_EN, coefficient -1 gives out_coeff_q=8380416.

Source files
------------

// File: rtl/bounded_coeff_sampler.sv
// ML-DSA ExpandS rejection sampler: bytes -> nibbles -> bounded signed coefficients.
// Optional `COEFF_MODQ_OUT_EN adds out_coeff_q, the coefficient reduced mod q.
module bounded_coeff_sampler #(
  parameter int ETA      = 2,
  parameter int IN_BYTES = 1,
  parameter int N_COEFF  = 256,
  parameter int COEFF_W  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [8*IN_BYTES-1:0]      in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [COEFF_W-1:0]  out_coeff,
  output logic [$clog2(N_COEFF)-1:0] out_idx,
  output logic                       busy,
  output logic                       done,
  output logic [15:0]                rej_cnt
`ifdef COEFF_MODQ_OUT_EN
  ,
  output logic [22:0]                out_coeff_q
`endif
);

  localparam int NIB    = 2 * IN_BYTES;
  localparam int PTR_W  = $clog2(NIB);
  localparam int IDX_W  = $clog2(N_COEFF);
  localparam int DATA_W = 8 * IN_BYTES;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  generate
    if (!(ETA == 2 || ETA == 4)) begin : g_bad_eta
      $error("bounded_coeff_sampler: ETA must be 2 or 4");
    end
    if (IN_BYTES < 1 || IN_BYTES > 8) begin : g_bad_in_bytes
      $error("bounded_coeff_sampler: IN_BYTES must be in 1..8");
    end
    if (N_COEFF < 2) begin : g_bad_n_coeff
      $error("bounded_coeff_sampler: N_COEFF must be at least 2");
    end
    if ((ETA == 4 && COEFF_W < 4) || (ETA == 2 && COEFF_W < 3)) begin : g_bad_coeff_w
      $error("bounded_coeff_sampler: COEFF_W too narrow for ETA");
    end
  endgenerate

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              full_q, full_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [15:0]       rej_q, rej_d;

  logic [3:0]        nib;
  logic [3:0]        nib_mod5;
  logic              accept;
  logic signed [4:0] coeff_full;
  logic              beat_hs;
  logic              consume;
  logic              last_nib;
  logic              last_coeff;

  // The buffer shifts right on every consumed nibble, so the current nibble is always bits [3:0].
  assign nib = buf_q[3:0];

  always_comb begin
    nib_mod5   = nib;
    accept     = 1'b0;
    coeff_full = '0;
    if (ETA == 4) begin
      accept     = (nib < 4'd9);
      coeff_full = 5'sd4 - $signed({1'b0, nib});
    end else begin
      if (nib >= 4'd10) begin
        nib_mod5 = nib - 4'd10;
      end else if (nib >= 4'd5) begin
        nib_mod5 = nib - 4'd5;
      end
      accept     = (nib != 4'd15);
      coeff_full = 5'sd2 - $signed({1'b0, nib_mod5});
    end
  end

  assign in_ready   = (state_q == S_RUN) && !full_q;
  assign out_valid  = (state_q == S_RUN) && full_q && accept;
  assign out_coeff  = out_valid ? COEFF_W'(coeff_full) : '0;
  assign out_idx    = idx_q;
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign rej_cnt    = rej_q;

  assign beat_hs    = in_valid && in_ready;
  assign consume    = (state_q == S_RUN) && full_q && (!accept || out_ready);
  assign last_nib   = (ptr_q == PTR_W'(NIB - 1));
  assign last_coeff = (idx_q == IDX_W'(N_COEFF - 1));

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    full_d  = full_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    rej_d   = rej_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          full_d  = 1'b0;
          ptr_d   = '0;
          idx_d   = '0;
          rej_d   = '0;
        end
      end
      S_RUN: begin
        if (beat_hs) begin
          buf_d  = in_data;
          ptr_d  = '0;
          full_d = 1'b1;
        end else if (consume) begin
          // Final accepted coefficient drops whatever nibbles remain in the buffer.
          if (accept && last_coeff) begin
            state_d = S_DONE;
            full_d  = 1'b0;
            ptr_d   = '0;
          end else begin
            if (accept) begin
              idx_d = idx_q + 1'b1;
            end else if (rej_q != 16'hFFFF) begin
              rej_d = rej_q + 16'd1;
            end
            if (last_nib) begin
              full_d = 1'b0;
            end else begin
              ptr_d = ptr_q + 1'b1;
              buf_d = buf_q >> 4;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        full_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      full_q  <= 1'b0;
      ptr_q   <= '0;
      idx_q   <= '0;
      rej_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      full_q  <= full_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      rej_q   <= rej_d;
    end
  end

`ifdef COEFF_MODQ_OUT_EN
  localparam logic signed [23:0] Q_MOD = 24'sd8380417;
  logic signed [23:0] coeff_ext;

  assign coeff_ext = 24'(coeff_full);

  always_comb begin
    out_coeff_q = '0;
    if (out_valid) begin
      if (coeff_ext < 0) begin
        out_coeff_q = 23'(Q_MOD + coeff_ext);
      end else begin
        out_coeff_q = 23'(coeff_ext);
      end
    end
  end
`endif

endmodule

// File: tb/tb_bounded_coeff_sampler.sv
// Directed bench for bounded_coeff_sampler: one ETA=2 and one ETA=4 instance sharing clock and reset.
module tb_bounded_coeff_sampler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        start2, in_valid2, out_ready2;
  logic [7:0]  in_data2;
  logic        in_ready2, out_valid2, busy2, done2;
  logic [3:0]  out_coeff2;
  logic [7:0]  out_idx2;
  logic [15:0] rej_cnt2;

  logic        start4, in_valid4, out_ready4;
  logic [7:0]  in_data4;
  logic        in_ready4, out_valid4, busy4, done4;
  logic [3:0]  out_coeff4;
  logic [7:0]  out_idx4;
  logic [15:0] rej_cnt4;

`ifdef COEFF_MODQ_OUT_EN
  logic [22:0] coeff_q2, coeff_q4;
`endif

  int vectors    = 0;
  int miscompares = 0;

  bounded_coeff_sampler #(.ETA(2), .IN_BYTES(1), .N_COEFF(256), .COEFF_W(4)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start2),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .in_data   (in_data2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .out_coeff (out_coeff2),
    .out_idx   (out_idx2),
    .busy      (busy2),
    .done      (done2),
    .rej_cnt   (rej_cnt2)
`ifdef COEFF_MODQ_OUT_EN
    ,
    .out_coeff_q (coeff_q2)
`endif
  );

  bounded_coeff_sampler #(.ETA(4), .IN_BYTES(1), .N_COEFF(256), .COEFF_W(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start4),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .in_data   (in_data4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .out_coeff (out_coeff4),
    .out_idx   (out_idx4),
    .busy      (busy4),
    .done      (done4),
    .rej_cnt   (rej_cnt4)
`ifdef COEFF_MODQ_OUT_EN
    ,
    .out_coeff_q (coeff_q4)
`endif
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one beat, waits (bounded) for in_ready, then returns one tick after the handshake edge.
  task automatic applyStimulus(input bit use4, input logic [7:0] data);
    if (use4) begin
      in_valid4 = 1'b1;
      in_data4  = data;
    end else begin
      in_valid2 = 1'b1;
      in_data2  = data;
    end
    for (int k = 0; k < 20; k++) begin
      if ((use4 ? in_ready4 : in_ready2) === 1'b1) break;
      step();
    end
    checkOutput("beat_ready", use4 ? in_ready4 : in_ready2, 1);
    step();
    if (use4) in_valid4 = 1'b0;
    else      in_valid2 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start2 = 0; in_valid2 = 0; in_data2 = '0; out_ready2 = 1;
    start4 = 0; in_valid4 = 0; in_data4 = '0; out_ready4 = 1;
    step(2);

    checkOutput("rst_in_ready",  in_ready2,  0);
    checkOutput("rst_out_valid", out_valid2, 0);
    checkOutput("rst_out_coeff", out_coeff2, 0);
    checkOutput("rst_out_idx",   out_idx2,   0);
    checkOutput("rst_busy",      busy2,      0);
    checkOutput("rst_done",      done2,      0);
    checkOutput("rst_rej_cnt",   rej_cnt2,   0);

    rst_n = 1'b1;
    step();
    checkOutput("idle_in_valid_ignored", in_ready2, 0);

    start2 = 1; start4 = 1;
    step();
    start2 = 0; start4 = 0;
    checkOutput("run_busy",     busy2,     1);
    checkOutput("run_in_ready", in_ready2, 1);

    $display("[TB] ETA=2 beat 0x40");
    applyStimulus(0, 8'h40);
    checkOutput("b40_valid0", out_valid2, 1);
    checkOutput("b40_coeff0", out_coeff2, 4'h2);
    checkOutput("b40_idx0",   out_idx2,   0);
    checkOutput("b40_inrdy0", in_ready2,  0);
    step();
    checkOutput("b40_valid1", out_valid2, 1);
    checkOutput("b40_coeff1", out_coeff2, 4'hE);
    checkOutput("b40_idx1",   out_idx2,   1);
    checkOutput("b40_rej",    rej_cnt2,   0);
    step();
    checkOutput("b40_empty_inrdy", in_ready2,  1);
    checkOutput("b40_empty_valid", out_valid2, 0);
    checkOutput("b40_empty_idx",   out_idx2,   2);

    $display("[TB] ETA=2 beat 0x3F");
    applyStimulus(0, 8'h3F);
    checkOutput("b3f_reject_valid", out_valid2, 0);
    step();
    checkOutput("b3f_rej",   rej_cnt2,   1);
    checkOutput("b3f_valid", out_valid2, 1);
    checkOutput("b3f_coeff", out_coeff2, 4'hF);
    checkOutput("b3f_idx",   out_idx2,   2);
    step();

    $display("[TB] ETA=4 beat 0x98");
    applyStimulus(1, 8'h98);
    checkOutput("b98_valid0", out_valid4, 1);
    checkOutput("b98_coeff0", out_coeff4, 4'hC);
    checkOutput("b98_idx0",   out_idx4,   0);
`ifdef COEFF_MODQ_OUT_EN
    checkOutput("b98_modq",   coeff_q4,   23'd8380413);
`endif
    step();
    checkOutput("b98_reject_valid", out_valid4, 0);
    checkOutput("b98_idx1",         out_idx4,   1);
    step();
    checkOutput("b98_rej",    rej_cnt4,  1);
    checkOutput("b98_inrdy",  in_ready4, 1);

    $display("[TB] backpressure on ETA=2");
    out_ready2 = 0;
    applyStimulus(0, 8'h21);
    for (int c = 0; c < 5; c++) begin
      checkOutput("bp_valid", out_valid2, 1);
      checkOutput("bp_coeff", out_coeff2, 4'h1);
      checkOutput("bp_idx",   out_idx2,   3);
      checkOutput("bp_inrdy", in_ready2,  0);
      step();
    end
    out_ready2 = 1;
    checkOutput("bp_release_valid", out_valid2, 1);
    step();
    checkOutput("bp_next_coeff", out_coeff2, 4'h0);
    checkOutput("bp_next_idx",   out_idx2,   4);
    step();
    checkOutput("bp_after_idx",   out_idx2,  5);
    checkOutput("bp_after_inrdy", in_ready2, 1);

    start2 = 1;
    step();
    start2 = 0;
    checkOutput("start_busy_ignored_idx",  out_idx2, 5);
    checkOutput("start_busy_ignored_busy", busy2,    1);

    $display("[TB] advancing to out_idx 100");
    for (int b = 0; b < 47; b++) begin
      applyStimulus(0, 8'h00);
      step(2);
    end
    checkOutput("adv_idx99", out_idx2, 99);
    applyStimulus(0, 8'h0F);
    step(2);
    checkOutput("adv_idx100", out_idx2, 100);
    checkOutput("adv_rej2",   rej_cnt2, 2);
    out_ready2 = 0;
    applyStimulus(0, 8'h00);
    checkOutput("mid_valid", out_valid2, 1);
    checkOutput("mid_idx",   out_idx2,   100);

    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", out_valid2, 0);
    checkOutput("async_rst_coeff", out_coeff2, 0);
    checkOutput("async_rst_idx",   out_idx2,   0);
    checkOutput("async_rst_busy",  busy2,      0);
    checkOutput("async_rst_inrdy", in_ready2,  0);
    checkOutput("async_rst_rej",   rej_cnt2,   0);
    checkOutput("async_rst_done",  done2,      0);
    step();
    rst_n = 1'b1;
    out_ready2 = 1;
    step();
    checkOutput("post_rst_no_resume", busy2, 0);

    $display("[TB] full polynomial of 0x00 beats");
    start2 = 1;
    step();
    start2 = 0;
    checkOutput("full_start_idx", out_idx2,  0);
    checkOutput("full_start_rej", rej_cnt2,  0);
    for (int i = 0; i < 128; i++) begin
      applyStimulus(0, 8'h00);
      checkOutput("full_coeff_lo", out_coeff2, 4'h2);
      checkOutput("full_idx_lo",   out_idx2,   2 * i);
      step();
      checkOutput("full_valid_hi", out_valid2, 1);
      checkOutput("full_coeff_hi", out_coeff2, 4'h2);
      checkOutput("full_idx_hi",   out_idx2,   2 * i + 1);
      if (i < 127) step();
    end
    start2 = 1;
    step();
    checkOutput("full_done",       done2,      1);
    checkOutput("full_done_valid", out_valid2, 0);
    checkOutput("full_done_inrdy", in_ready2,  0);
    checkOutput("full_done_busy",  busy2,      0);
    step();
    start2 = 0;
    checkOutput("full_done_once",        done2, 0);
    checkOutput("start_in_done_ignored", busy2, 0);
    in_valid2 = 1;
    in_data2  = 8'h00;
    for (int c = 0; c < 3; c++) begin
      checkOutput("beat129_inrdy", in_ready2,  0);
      checkOutput("beat129_valid", out_valid2, 0);
      step();
    end
    in_valid2 = 0;

    $display("[TB] ETA=2 coefficient -1 again");
    start2 = 1;
    step();
    start2 = 0;
    applyStimulus(0, 8'h03);
    checkOutput("neg1_coeff", out_coeff2, 4'hF);
    checkOutput("neg1_idx",   out_idx2,   0);
`ifdef COEFF_MODQ_OUT_EN
    checkOutput("neg1_modq",  coeff_q2,   23'd8380416);
`endif
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
